// File: rtl/cpu_pkg.sv
// Constants shared by the PC register, next-PC select and the fetch stage.
package cpu_pkg;
   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/imem.sv
// Instruction memory: synchronous write port, asynchronous read port, not cleared by reset.
module imem
   import cpu_pkg::*;
#(
   parameter int unsigned AW = ADDR_W,
   parameter int unsigned DW = INSTR_W
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: imem read into a one-entry IF/ID register with hold and squash.
module if_stage
   import cpu_pkg::*;
#(
   parameter int unsigned         ADDR_W  = cpu_pkg::ADDR_W,
   parameter int unsigned         INSTR_W = cpu_pkg::INSTR_W,
   parameter logic [INSTR_W-1:0]  NOP     = cpu_pkg::NOP
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ADDR_W-1:0]  pc_val,
   input  logic               stall,
   input  logic               flush,
   input  logic               load_en,
   input  logic [ADDR_W-1:0]  load_addr,
   input  logic [INSTR_W-1:0] load_data,
   output logic [ADDR_W-1:0]  pc_plus1,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic               if_id_valid
);

   logic [INSTR_W-1:0] fetch_word;
   logic               mem_we;

   // Flush does not block the write; only reset does.
   assign mem_we = load_en & rst_n;

   imem #(
      .AW (ADDR_W),
      .DW (INSTR_W)
   ) u_imem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (pc_val),
      .rdata (fetch_word)
   );

   assign pc_plus1 = pc_val + ADDR_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         if_id_instr <= NOP;
         if_id_pc    <= '0;
         if_id_valid <= 1'b0;
      end else if (load_en) begin
         // A load bubbles the pipe but keeps the last PC.
         if_id_instr <= NOP;
         if_id_valid <= 1'b0;
      end else if (!stall) begin
         if_id_instr <= fetch_word;
         if_id_pc    <= pc_val;
         if_id_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed vector bench for if_stage: reset, load/fetch, stall, flush, wrap and reset-mid-load.
module tb_if_stage;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   typedef struct {
      logic          rst_n;
      logic [AW-1:0] pc_val;
      logic          stall;
      logic          flush;
      logic          load_en;
      logic [AW-1:0] load_addr;
      logic [DW-1:0] load_data;
      logic [DW-1:0] exp_instr;
      logic [AW-1:0] exp_pc;
      logic          exp_valid;
      logic [AW-1:0] exp_plus1;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] pc_val = '0;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic          load_en = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [DW-1:0] load_data = '0;
   logic [AW-1:0] pc_plus1;
   logic [DW-1:0] if_id_instr;
   logic [AW-1:0] if_id_pc;
   logic          if_id_valid;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t vecs[$];

   if_stage #(
      .ADDR_W  (AW),
      .INSTR_W (DW),
      .NOP     (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_val      (pc_val),
      .stall       (stall),
      .flush       (flush),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .pc_plus1    (pc_plus1),
      .if_id_instr (if_id_instr),
      .if_id_pc    (if_id_pc),
      .if_id_valid (if_id_valid)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [AW-1:0] pc, input logic st, input logic fl,
                      input logic ld, input logic [AW-1:0] la, input logic [DW-1:0] lw,
                      input logic [DW-1:0] ei, input logic [AW-1:0] ep, input logic ev,
                      input logic [AW-1:0] e1);
      vec_t v;
      v.rst_n = r; v.pc_val = pc; v.stall = st; v.flush = fl;
      v.load_en = ld; v.load_addr = la; v.load_data = lw;
      v.exp_instr = ei; v.exp_pc = ep; v.exp_valid = ev; v.exp_plus1 = e1;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      rst_n = v.rst_n; pc_val = v.pc_val; stall = v.stall; flush = v.flush;
      load_en = v.load_en; load_addr = v.load_addr; load_data = v.load_data;
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input int idx, input vec_t v);
      chk($sformatf("v%0d instr", idx), if_id_instr, v.exp_instr);
      chk($sformatf("v%0d pc", idx), DW'(if_id_pc), DW'(v.exp_pc));
      chk($sformatf("v%0d valid", idx), DW'(if_id_valid), DW'(v.exp_valid));
      chk($sformatf("v%0d plus1", idx), DW'(pc_plus1), DW'(v.exp_plus1));
   endtask

   initial begin
      //   rst pc  st fl ld addr data           instr          pc  v  +1
      add(0,  7, 0, 0, 0,  0, 32'h0,         32'h00000000,  0, 0, 8);
      add(0,  7, 0, 0, 0,  0, 32'h0,         32'h00000000,  0, 0, 8);
      add(1,  7, 0, 0, 1,  0, 32'h11111111,  32'h00000000,  0, 0, 8);
      add(1,  7, 0, 0, 1,  1, 32'h22222222,  32'h00000000,  0, 0, 8);
      add(1,  7, 0, 0, 1,  2, 32'h33333333,  32'h00000000,  0, 0, 8);
      add(1,  7, 0, 0, 1,  3, 32'h44444444,  32'h00000000,  0, 0, 8);
      add(1,  0, 0, 0, 0,  0, 32'h0,         32'h11111111,  0, 1, 1);
      add(1,  1, 0, 0, 0,  0, 32'h0,         32'h22222222,  1, 1, 2);
      add(1,  2, 0, 0, 0,  0, 32'h0,         32'h33333333,  2, 1, 3);
      add(1,  3, 0, 0, 0,  0, 32'h0,         32'h44444444,  3, 1, 4);
      add(1,  2, 0, 0, 0,  0, 32'h0,         32'h33333333,  2, 1, 3);
      add(1,  3, 1, 0, 0,  0, 32'h0,         32'h33333333,  2, 1, 4);
      add(1,  3, 1, 0, 0,  0, 32'h0,         32'h33333333,  2, 1, 4);
      add(1,  3, 1, 0, 0,  0, 32'h0,         32'h33333333,  2, 1, 4);
      add(1,  3, 0, 0, 0,  0, 32'h0,         32'h44444444,  3, 1, 4);
      add(1,  3, 1, 1, 0,  0, 32'h0,         32'h00000000,  0, 0, 4);
      add(1,  1, 0, 0, 0,  0, 32'h0,         32'h22222222,  1, 1, 2);
      add(1, 31, 0, 0, 1, 31, 32'hDEADBEEF,  32'h00000000,  1, 0, 0);
      add(1, 31, 0, 0, 0,  0, 32'h0,         32'hDEADBEEF, 31, 1, 0);
      add(1,  0, 0, 0, 1,  5, 32'hAAAA0000,  32'h00000000, 31, 0, 1);
      add(0,  0, 0, 0, 1,  5, 32'hBBBB0000,  32'h00000000,  0, 0, 1);
      add(1,  5, 0, 0, 0,  0, 32'h0,         32'hAAAA0000,  5, 1, 6);
      add(1,  5, 0, 1, 1,  6, 32'hCAFE0001,  32'h00000000,  0, 0, 6);
      add(1,  6, 0, 0, 0,  0, 32'h0,         32'hCAFE0001,  6, 1, 7);
      add(1,  6, 1, 0, 1,  6, 32'h12345678,  32'h00000000,  6, 0, 7);
      add(1,  6, 0, 0, 0,  0, 32'h0,         32'h12345678,  6, 1, 7);

      foreach (vecs[i]) begin
         apply(vecs[i]);
         check_outputs(i, vecs[i]);
      end

      // Flush followed by a long stall keeps the bubble in place.
      @(negedge clk);
      pc_val = 2; stall = 1'b0; flush = 1'b1; load_en = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0; stall = 1'b1;
      for (int unsigned c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk($sformatf("stall_bubble%0d valid", c), DW'(if_id_valid), 32'd0);
         chk($sformatf("stall_bubble%0d instr", c), if_id_instr, 32'h0);
      end
      @(negedge clk);
      stall = 1'b0;
      @(posedge clk); #1;
      chk("post_bubble instr", if_id_instr, 32'h33333333);
      chk("post_bubble pc", DW'(if_id_pc), 32'd2);

      // Combinational incrementer across the full address range.
      for (int unsigned a = 0; a < 32; a++) begin
         pc_val = AW'(a);
         #1;
         chk($sformatf("plus1_%0d", a), DW'(pc_plus1), (a == 31) ? 32'd0 : DW'(a + 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, expected finish before 100000");
      $fatal(1);
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage directly downstream of the program counter register. Every cycle it takes the 5-bit `pc_val`, reads the 32-word instruction memory, and latches the instruction and its PC into the IF/ID pipeline register for the decoder. It also provides `pc_plus1` to the next-PC select logic, and a synchronous load port for filling instruction memory before or between runs. Stall and flush inputs come from the hazard/branch logic.

## Interface
Parameters:
- `ADDR_W`, 5: instruction address width; memory depth is 2^ADDR_W = 32 words.
- `INSTR_W`, 32: instruction width.
- `NOP`, 32'h0000_0000: instruction word driven when the IF/ID register holds no valid instruction.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `pc_val`  in  ADDR_W: current PC from the PC register.
- `stall`  in  1: hold the IF/ID register.
- `flush`  in  1: squash the IF/ID contents (taken branch or jump).
- `load_en`  in  1: instruction-memory write strobe.
- `load_addr`  in  ADDR_W: write address.
- `load_data`  in  INSTR_W: write data.
- `pc_plus1`  out  ADDR_W: `pc_val + 1`, combinational, wraps modulo 32.
- `if_id_instr`  out  INSTR_W: registered instruction.
- `if_id_pc`  out  ADDR_W: registered PC of `if_id_instr`.
- `if_id_valid`  out  1: `if_id_instr` is a real instruction.

## Operation
- The memory is 32 x INSTR_W. It is written only through the load port. Reset does not clear it.
- The outputs `if_id_instr`, `if_id_pc` and `if_id_valid` update each rising edge. The priority order is: reset, then flush, then load, then stall, then fetch.
  - Reset (`rst_n`=0): `if_id_instr`=NOP, `if_id_pc`=0, `if_id_valid`=0.
  - `flush`=1: same values as reset. Flush overrides `stall`.
  - `load_en`=1 (without flush): perform the memory write. Set `if_id_valid`=0 and `if_id_instr`=NOP. Leave `if_id_pc` unchanged. No fetch happens while loading.
  - `stall`=1: all three outputs hold their values.
  - Otherwise: `if_id_instr` = mem[`pc_val`], `if_id_pc` = `pc_val`, `if_id_valid`=1.
- The load write is gated only by `load_en` and `rst_n`. A flush in the same cycle still performs the write.
- Read-during-write to the same address:
  - The fetch path never captures the new data in the same edge, because a load suppresses fetch.
  - The next unstalled fetch of that address returns the new data.
- `pc_plus1` arithmetic: ADDR_W-bit unsigned add. 31 + 1 = 0, with no carry output.
- There is no internal FSM. The only state is the memory plus the three IF/ID registers, which behave like a one-entry pipeline register with hold and squash.

## Timing
- Fetch latency is 1 cycle: a `pc_val` present before edge N appears on the `if_id_*` outputs after edge N.
- `pc_plus1` has zero latency and is purely combinational from `pc_val`.
- `stall`, `flush` and `load_en` are sampled at the same edge as `pc_val`. Their effect is visible immediately after that edge.
- Stalling is the PC owner's responsibility. While `stall`=1 the PC register must hold, otherwise fetches are lost. This block does not re-fetch.
- Reset takes effect on the first rising edge with `rst_n`=0. It works mid-stall or mid-load: a load write in that cycle is dropped, and the memory keeps its prior contents at that address.
- After `rst_n` returns to 1, the first fetch occurs on the next edge.

## Structure
- Shared package `cpu_pkg`: `ADDR_W`, `INSTR_W`, `NOP`. The PC register and the next-PC select logic use the same constants.
- One sub-module, `imem`: a 32 x INSTR_W array with a synchronous write port and an asynchronous read port.
- The IF/ID register, the priority logic and the `pc_plus1` adder live in `if_stage` itself.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `pc_val`=7 -> `if_id_valid`=0, `if_id_instr`=0, `if_id_pc`=0. `pc_plus1`=8 throughout.
- **Load then fetch:**
  - Load mem[0..3] = 32'h11111111, 22222222, 33333333, 44444444; `if_id_valid` stays 0 during the loads.
  - Then drive `pc_val` = 0, 1, 2, 3 -> `if_id_instr` follows one cycle later with `if_id_pc` = 0..3 and `if_id_valid`=1.
- **Stall:**
  - Fetch `pc_val`=2, then assert `stall` for 3 cycles while `pc_val` changes to 3 -> outputs hold 32'h33333333 / pc 2.
  - Release `stall` -> the next edge shows pc 3.
- **Flush beats stall:** with `stall`=1 and `flush`=1 together -> `if_id_valid`=0 and `if_id_instr`=NOP. With `flush`=0 on the next edge and `pc_val`=1 -> 32'h22222222 with `if_id_valid`=1.
- **Wrap:**
  - `pc_val`=31 -> `pc_plus1`=0.
  - Load mem[31]=32'hDEADBEEF and fetch address 31 -> `if_id_pc`=31, `if_id_instr`=32'hDEADBEEF.
- **Reset mid-load:** mem[5]=32'hAAAA0000, then `load_en`=1 with address 5 / data 32'hBBBB0000 while `rst_n`=0 -> a later fetch of address 5 returns 32'hAAAA0000.
